riscv_fetch: RTL

Instruction fetch stage: the producer side of the fetch/decode handshake consumed by `riscv_decode`. It generates sequential PCs from a boot vector and issues single-outstanding requests to the instruction memory/cache. Returned words are buffered in a 2-entry queue and presented to decode as `fetch_valid_o`/`fetch_instr_o`/`fetch_pc_o`. Branch redirects from decode flush the queue and squash any in-flight response.

---
 rtl/riscv_fetch_pkg.sv | 23 ++
 rtl/riscv_fetch_if.sv | 31 +++
 rtl/riscv_fetch_fifo.sv | 54 +++++
 rtl/riscv_fetch.sv | 86 ++++++++
 4 files changed

// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// The queue entry layout is {fault, pc, instr}, 65 bits in total.
package riscv_fetch_pkg;

    typedef enum logic {
        FETCH_STATE_RUN   = 1'b0,
        FETCH_STATE_FAULT = 1'b1
    } fetch_state_e;

    localparam int FETCH_FIFO_DEPTH = 2;
    localparam int FETCH_ENTRY_W    = 65;

    typedef struct packed {
        logic        fault;
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/riscv_fetch_if.sv
// Fetch-stage bus bundle: the decode-facing handshake and the icache request/response port.
// The fetch stage uses the master modport; decode and icache together form the slave side.
interface riscv_fetch_if;
    logic        fetch_valid_o;
    logic [31:0] fetch_instr_o;
    logic [31:0] fetch_pc_o;
    logic        fetch_fault_o;
    logic        fetch_accept_i;
    logic        fetch_branch_i;
    logic [31:0] fetch_branch_pc_i;
    logic        icache_rd_o;
    logic [31:0] icache_pc_o;
    logic        icache_accept_i;
    logic        icache_valid_i;
    logic [31:0] icache_inst_i;
    logic        icache_error_i;

    modport master (
        output fetch_valid_o, fetch_instr_o, fetch_pc_o, fetch_fault_o,
        output icache_rd_o, icache_pc_o,
        input  fetch_accept_i, fetch_branch_i, fetch_branch_pc_i,
        input  icache_accept_i, icache_valid_i, icache_inst_i, icache_error_i
    );

    modport slave (
        input  fetch_valid_o, fetch_instr_o, fetch_pc_o, fetch_fault_o,
        input  icache_rd_o, icache_pc_o,
        output fetch_accept_i, fetch_branch_i, fetch_branch_pc_i,
        output icache_accept_i, icache_valid_i, icache_inst_i, icache_error_i
    );
endinterface

// File: rtl/riscv_fetch_fifo.sv
// Two-entry fetch queue; the head is presented straight from storage registers.
// Push and pop in the same cycle are legal even when full.
module riscv_fetch_fifo
    import riscv_fetch_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  fetch_entry_t data_in,
    output fetch_entry_t data_out,
    output logic         valid,
    output logic         full,
    output logic [1:0]   count
);
    fetch_entry_t mem_q [FETCH_FIFO_DEPTH];
    logic         rd_ptr_q;
    logic         wr_ptr_q;
    logic [1:0]   count_q;
    logic         do_push;
    logic         do_pop;

    assign valid    = (count_q != 2'd0);
    assign full     = (count_q == 2'd2);
    assign count    = count_q;
    assign data_out = mem_q[rd_ptr_q];
    assign do_pop   = pop & valid;
    assign do_push  = push & (~full | do_pop);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < FETCH_FIFO_DEPTH; i++) mem_q[i] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (flush) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_in;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) rd_ptr_q <= ~rd_ptr_q;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: rtl/riscv_fetch.sv
// Instruction fetch stage: sequential PC generation, single-outstanding icache requests,
// a two-entry instruction queue towards decode, and branch redirect with response squash.
//   state             | meaning
//   FETCH_STATE_RUN   | issuing requests while queue credit allows
//   FETCH_STATE_FAULT | bus error queued; no requests until a branch
module riscv_fetch
    import riscv_fetch_pkg::*;
#(
    parameter logic [31:0] BOOT_VECTOR = 32'h0000_0000
) (
    input  logic          clk_i,
    input  logic          rst_i,
    riscv_fetch_if.master bus
);
    fetch_state_e state_q;
    logic [31:0]  pc_q;
    logic         outstanding_q;
    logic         drop_q;

    fetch_entry_t head;
    fetch_entry_t push_entry;
    logic         fifo_valid;
    logic         fifo_full;
    logic [1:0]   fifo_count;
    logic         pop;
    logic         push;
    logic [2:0]   used;
    logic         issue;
    logic         take;

    assign pop  = fifo_valid & bus.fetch_accept_i & ~bus.fetch_branch_i;
    assign push = bus.icache_valid_i & ~drop_q & ~bus.fetch_branch_i;
    assign used = {1'b0, fifo_count} + {2'b00, outstanding_q} - {2'b00, pop};

    // Request must be visible before the first edge after reset release, so rst_i gates it directly.
    assign issue = rst_i & (state_q == FETCH_STATE_RUN) & ~bus.fetch_branch_i
                 & (used < 3'd2) & (~outstanding_q | bus.icache_valid_i);
    assign take  = issue & bus.icache_accept_i;

    assign bus.icache_rd_o = issue;
    assign bus.icache_pc_o = rst_i ? pc_q : 32'h0;

    // A pushed response always belongs to the last accepted request, which is pc_q - 4
    // (a redirect while outstanding arms drop_q, so its response is never pushed).
    assign push_entry = '{fault: bus.icache_error_i, pc: pc_q - 32'd4, instr: bus.icache_inst_i};

    riscv_fetch_fifo u_fifo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .flush    (bus.fetch_branch_i),
        .push     (push & (~fifo_full | pop)),
        .pop      (pop),
        .data_in  (push_entry),
        .data_out (head),
        .valid    (fifo_valid),
        .full     (fifo_full),
        .count    (fifo_count)
    );

    assign bus.fetch_valid_o = fifo_valid;
    assign bus.fetch_pc_o    = head.pc;
    assign bus.fetch_instr_o = head.instr;
    assign bus.fetch_fault_o = fifo_valid & head.fault;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q       <= FETCH_STATE_RUN;
            pc_q          <= BOOT_VECTOR;
            outstanding_q <= 1'b0;
            drop_q        <= 1'b0;
        end else begin
            if (take) outstanding_q <= 1'b1;
            else if (bus.icache_valid_i) outstanding_q <= 1'b0;

            if (bus.fetch_branch_i) begin
                state_q <= FETCH_STATE_RUN;
                pc_q    <= align_pc(bus.fetch_branch_pc_i);
                drop_q  <= outstanding_q & ~bus.icache_valid_i;
            end else begin
                if (take) pc_q <= pc_q + 32'd4;
                if (push & bus.icache_error_i) state_q <= FETCH_STATE_FAULT;
                if (bus.icache_valid_i & drop_q) drop_q <= 1'b0;
            end
        end
    end
endmodule
